// File: rtl/sram_bank_write_arbiter_if.sv
// Lane-side write requests and bank-side registered write ports of the 4-bank data SRAM.
// The master modport is the lane/LSU side. The slave modport is the arbiter.
interface sram_bank_write_arbiter_if #(
  parameter int AW   = 14,
  parameter int DW   = 32,
  parameter int CNTW = 16
);
  logic [3:0]          req_valid;
  logic [4*AW-1:0]     req_addr;
  logic [4*DW-1:0]     req_wdata;
  logic [3:0]          req_ready;
  logic [3:0]          bank_we;
  logic [4*(AW-2)-1:0] bank_waddr;
  logic [4*DW-1:0]     bank_wdata;
  logic [CNTW-1:0]     conflict_cnt;
  logic                idle;

  modport master (
    output req_valid, req_addr, req_wdata,
    input  req_ready, bank_we, bank_waddr, bank_wdata, conflict_cnt, idle
  );

  modport slave (
    input  req_valid, req_addr, req_wdata,
    output req_ready, bank_we, bank_waddr, bank_wdata, conflict_cnt, idle
  );
endinterface

// File: rtl/sram_bank_write_arbiter.sv
// Per-bank round-robin write arbiter. Four lanes compete for four word-interleaved banks.
// The grant (req_ready) is combinational in the same cycle. Bank writes are registered one cycle later.
// Losing lanes stall on !req_ready. The banks never back-pressure.
module sram_bank_write_arbiter #(
  parameter int AW   = 14,
  parameter int DW   = 32,
  parameter int CNTW = 16
) (
  input logic                   clk,
  input logic                   rstn,
  sram_bank_write_arbiter_if.slave bus
);
  localparam int RW = AW - 2;

  logic [AW-1:0]   w_addr  [4];
  logic [DW-1:0]   w_wdata [4];
  logic [3:0]      w_cand  [4];
  logic [3:0]      w_gnt   [4];
  logic [1:0]      w_win   [4];
  logic [3:0]      w_ready_raw;
  logic [2:0]      w_stalls;
  logic [CNTW:0]   w_cnt_sum;

  logic [1:0]      r_ptr   [4];
  logic [3:0]      r_we;
  logic [RW-1:0]   r_waddr [4];
  logic [DW-1:0]   r_wdata [4];
  logic [CNTW-1:0] r_cnt;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign w_addr[i]  = bus.req_addr[i*AW +: AW];
    assign w_wdata[i] = bus.req_wdata[i*DW +: DW];
    for (genvar b = 0; b < 4; b++) begin : g_cand
      assign w_cand[b][i] = bus.req_valid[i] & (w_addr[i][1:0] == 2'(b));
    end
  end

  // Search order per bank starts at ptr[b]. The first candidate found in that order wins.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      w_gnt[b] = '0;
      w_win[b] = '0;
      for (int k = 3; k >= 0; k--) begin
        if (w_cand[b][2'(int'(r_ptr[b]) + k)]) begin
          w_gnt[b] = '0;
          w_gnt[b][2'(int'(r_ptr[b]) + k)] = 1'b1;
          w_win[b] = 2'(int'(r_ptr[b]) + k);
        end
      end
    end
  end

  assign w_ready_raw   = w_gnt[0] | w_gnt[1] | w_gnt[2] | w_gnt[3];
  assign bus.req_ready = rstn ? w_ready_raw : 4'b0000;

  always_comb begin
    w_stalls = '0;
    for (int i = 0; i < 4; i++) begin
      w_stalls = w_stalls + 3'(bus.req_valid[i] & ~bus.req_ready[i]);
    end
  end

  assign w_cnt_sum = {1'b0, r_cnt} + (CNTW+1)'(w_stalls);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_we  <= '0;
      r_cnt <= '0;
      for (int b = 0; b < 4; b++) begin
        r_ptr[b]   <= '0;
        r_waddr[b] <= '0;
        r_wdata[b] <= '0;
      end
    end else begin
      r_cnt <= w_cnt_sum[CNTW] ? {CNTW{1'b1}} : w_cnt_sum[CNTW-1:0];
      for (int b = 0; b < 4; b++) begin
        r_we[b] <= |w_cand[b];
        if (|w_cand[b]) begin
          r_waddr[b] <= w_addr[w_win[b]][AW-1:2];
          r_wdata[b] <= w_wdata[w_win[b]];
          r_ptr[b]   <= w_win[b] + 2'd1;
        end
      end
    end
  end

  for (genvar b = 0; b < 4; b++) begin : g_bank
    assign bus.bank_waddr[b*RW +: RW] = r_waddr[b];
    assign bus.bank_wdata[b*DW +: DW] = r_wdata[b];
  end

  assign bus.bank_we      = r_we;
  assign bus.conflict_cnt = r_cnt;
  assign bus.idle         = ~|bus.req_valid & ~|r_we;
endmodule
